// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: access sizes, FSM states,
// and the lane-enable and alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = |addr_lo;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store stage (master) and the data
// memory controller (slave).
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl_byte_array.sv
// Word-organised storage with per-lane write enables; synchronous write,
// combinational read. Contents are deliberately not reset.
module dmem_byte_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  localparam int IDX_W = $clog2(DEPTH / LANES),
  localparam int DATA_W = LANES * WIDTH
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [LANES-1:0]  be_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH / LANES];

  // Write only the enabled lanes of the addressed word
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (be_i[l]) begin
          mem_q[idx_i][l*WIDTH +: WIDTH] <= wdata_i[l*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/data_mem_ctrl.sv
// Clocked data memory controller: latches a request, waits WAIT_STATES cycles,
// performs a lane-masked store or an extended load, then pulses a response.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WIDTH       = 8,
  parameter int LANES       = 4,
  parameter int WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = LANES * WIDTH;
  localparam int LANE_W = $clog2(LANES);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              req_ready_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept_s;
  logic              bad_s;
  logic              mem_we_s;
  logic [LANES-1:0]  be_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] load_s;
  logic [DATA_W-1:0] wlane_s;

  assign accept_s = bus.req_valid && req_ready_q;
  assign bad_s    = access_err(bus.req_size, bus.req_addr[1:0]);
  assign be_s     = lane_mask(size_q, addr_q[1:0]);
  // The write lands on the edge that leaves ACCESS; an async reset drops it.
  assign mem_we_s = (state_q == ACCESS) && we_q;

  dmem_byte_array #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .be_i    (be_s),
    .idx_i   (addr_q[ADDR_W-1:LANE_W]),
    .wdata_i (wlane_s),
    .rdata_o (rd_word_s)
  );

  // Load extension and store-data lane replication
  always_comb begin
    shifted_s = rd_word_s >> (WIDTH * int'(addr_q[1:0]));
    load_s    = rd_word_s;
    wlane_s   = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        load_s  = {{(DATA_W-WIDTH){shifted_s[WIDTH-1] & ~uns_q}}, shifted_s[WIDTH-1:0]};
        wlane_s = {LANES{wdata_q[WIDTH-1:0]}};
      end
      SZ_HALF: begin
        load_s  = {{(DATA_W-2*WIDTH){shifted_s[2*WIDTH-1] & ~uns_q}}, shifted_s[2*WIDTH-1:0]};
        wlane_s = {(LANES/2){wdata_q[2*WIDTH-1:0]}};
      end
      default: begin
        load_s  = rd_word_s;
        wlane_s = wdata_q;
      end
    endcase
  end

  // Controller FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b1;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            we_q        <= bus.req_we;
            uns_q       <= bus.req_unsigned;
            size_q      <= bus.req_size;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (bad_s) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= {DATA_W{1'b0}};
            end else if (WAIT_STATES == 0) begin
              state_q <= ACCESS;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? {DATA_W{1'b0}} : load_s;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= {DATA_W{1'b0}};
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Byte-addressable, little-endian data memory with a clocked controller, the multi-cycle successor to the single-cycle combinational data memory.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads and misalignment detection.
- Access latency is set by a parameter and controlled through a valid/ready request and response handshake.
- Sits between the load/store stage and data storage in the pipelined and multi-cycle MIPS cores.

Parameters:
- DEPTH, 1024, memory size in bytes. Must be a power of two and a multiple of LANES.
- WIDTH, 8, bits per byte lane.
- LANES, 4, byte lanes per word. Word width is LANES*WIDTH.
- WAIT_STATES, 1, extra cycles between request accept and data commit or capture. Legal range 0..7.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request. High only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word. 11 is illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  $clog2(DEPTH)  byte address.
- req_wdata  in  LANES*WIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse. No backpressure.
- rsp_rdata  out  LANES*WIDTH  extended load data. 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal size.

Behaviour:
- Reset values: state=IDLE, req_ready=1 after reset deasserts, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not reset.
- Reset mid-operation: the transaction is aborted with no response. A store not yet committed is never written.
- Request acceptance: a request is accepted on a rising edge where req_valid && req_ready (cycle T). req_* are latched at T and may change afterwards.
- Error conditions, checked at accept:
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - req_size==11.
- Error handling: no memory write occurs. The FSM goes straight to RESP; rsp_valid=1 and rsp_err=1 at T+1, with rsp_rdata=0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE -> WAIT when a legal request is accepted and WAIT_STATES>0. The counter is loaded with WAIT_STATES-1.
  - IDLE -> ACCESS when a legal request is accepted and WAIT_STATES==0.
  - WAIT decrements the counter each cycle and moves to ACCESS when the counter reaches 0.
  - ACCESS: a store writes only its enabled lanes at the edge leaving ACCESS; a load captures the extended read data into the rsp_rdata register. Then -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0 in RESP, so the next accept is no earlier than the cycle after.
- Latency: a legal request accepted at T gives rsp_valid at T+2+WAIT_STATES. Throughput is one transaction per 3+WAIT_STATES cycles.
- Store lanes:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes addr[1]*2 and +1 with wdata[15:0];
  - word writes all four lanes.
  - Other bytes are untouched.
- Load extension: a byte load takes bit 7 of the selected byte as the sign bit; a half load takes bit 15. Word loads are passed through.
- Storage: word-organised, DEPTH/LANES entries, with a per-lane write enable. The word index is addr[$clog2(DEPTH)-1:$clog2(LANES)]. Read is combinational from the array; only the controller output is registered. There is no wrap-around, because aligned accesses never cross a word boundary.
- Read-after-write: a load accepted after a store's RESP returns the newly stored data.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state enum IDLE/WAIT/ACCESS/RESP;
  - the function computing the lane-enable mask from size and addr.
- One sub-module, dmem_byte_array: a word-organised array with LANES byte write enables, a synchronous write and a combinational read, parameterised by DEPTH, WIDTH and LANES.

Test Plan:
- Word store then load, WAIT_STATES=1: store addr 0x010, data 0xDEADBEEF, then load word at 0x010 -> rsp_valid exactly 3 cycles after each accept; load returns rdata=0xDEADBEEF, err=0.
- Sub-word loads on 0x010 (0xDEADBEEF):
  - lb at 0x013 -> 0xFFFFFFDE;
  - lbu at 0x013 -> 0x000000DE;
  - lh at 0x010 -> 0xFFFFBEEF;
  - lhu at 0x012 -> 0x0000DEAD.
- Byte and half stores: sb 0x55 to 0x011, then sh 0x1234 to 0x012, then lw 0x010 -> 0x123455EF. No other lanes change.
- Misalignment: sh to 0x021 and lw at 0x022 -> rsp_err=1 at T+1 with rdata=0. A following lw at 0x020 shows the old contents, unchanged.
- Latency sweep: WAIT_STATES=0 and WAIT_STATES=7 -> rsp_valid at T+2 and T+9. req_ready is low from T+1 through the RESP cycle.
- Reset during WAIT of a store of 0xCAFEBABE to 0x030 -> no rsp_valid, req_ready=1 after reset. A subsequent lw at 0x030 returns the value stored before the aborted store.
